// File: rtl/pr_bridge_pkg.sv
// ============================================================================
// Module   : pr_bridge_pkg
// Brief    : State encodings and default constants for the processor-bus bridge.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pr_bridge_pkg;

  localparam int          CP0_DEV_CNT = 6;
  localparam logic [31:0] PR_BASE     = 32'h0000_7F00;
  localparam int          PR_WIN_BITS = 4;
  localparam int          PR_TIMEOUT  = 15;

  localparam logic [1:0] PR_ST_IDLE   = 2'd0;
  localparam logic [1:0] PR_ST_ACCESS = 2'd1;
  localparam logic [1:0] PR_ST_RESP   = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = PR_ST_IDLE,
    ST_ACCESS = PR_ST_ACCESS,
    ST_RESP   = PR_ST_RESP
  } pr_state_t;

endpackage

`default_nettype wire

// File: rtl/pr_irq_sync.sv
// ============================================================================
// Module   : pr_irq_sync
// Brief    : Two-flop interrupt synchroniser with a per-bit enable mask.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pr_irq_sync
  import pr_bridge_pkg::*;
#(
  parameter int WIDTH = CP0_DEV_CNT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] irq,
  input  logic [WIDTH-1:0] mask,
  output logic [WIDTH-1:0] hw_int
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= irq;
      r_sync <= r_meta;
    end
  end

  assign hw_int = r_sync & mask;

endmodule

`default_nettype wire

// File: rtl/pr_bridge.sv
// ============================================================================
// Module   : pr_bridge
// Brief    : CPU-to-device bus bridge: decode, req/ack sequencing with timeout,
//            interrupt synchronisation. Define PR_IRQ_MASK_EN for IRQMASK window.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pr_bridge
  import pr_bridge_pkg::*;
#(
  parameter int          DEV_CNT = CP0_DEV_CNT,
  parameter logic [31:0] BASE    = PR_BASE,
  parameter int          TIMEOUT = PR_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pr_req,
  input  logic                  pr_we,
  input  logic [31:0]           pr_addr,
  input  logic [31:0]           pr_wdata,
  output logic [31:0]           pr_rdata,
  output logic                  pr_ready,
  output logic                  pr_err,
  output logic [DEV_CNT-1:0]    dev_sel,
  output logic                  dev_we,
  output logic [1:0]            dev_addr,
  output logic [31:0]           dev_wdata,
  input  logic [32*DEV_CNT-1:0] dev_rdata,
  input  logic [DEV_CNT-1:0]    dev_ack,
  input  logic [DEV_CNT-1:0]    dev_irq,
  output logic [DEV_CNT-1:0]    hw_int
);

  localparam int                     c_cnt_w    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_cnt_w-1:0]     c_cnt_last = c_cnt_w'(TIMEOUT - 1);
  localparam logic [PR_WIN_BITS-1:0] c_win_dev  = PR_WIN_BITS'(DEV_CNT);

  pr_state_t              r_state, w_state_nxt;
  logic [PR_WIN_BITS-1:0] r_idx;
  logic                   r_we;
  logic [1:0]             r_addr;
  logic [31:0]            r_wdata;
  logic [c_cnt_w-1:0]     r_cnt;
  logic [31:0]            r_rdata;
  logic                   r_err;
  logic                   r_ready;

  logic [PR_WIN_BITS-1:0] w_idx;
  logic                   w_win_ok;
  logic                   w_hit;
  logic                   w_dev_ack;
  logic [31:0]            w_dev_rd;
  logic [DEV_CNT-1:0]     w_sel;
  logic                   w_accept;
  logic                   w_resp;
  logic                   w_resp_err;
  logic [31:0]            w_resp_rdata;
  logic                   w_cnt_inc;
  logic [DEV_CNT-1:0]     w_irq_mask;
`ifdef PR_IRQ_MASK_EN
  logic [DEV_CNT-1:0]     r_mask;
  logic                   w_mask_wr;
`endif

  assign w_idx = pr_addr[7:4];
`ifdef PR_IRQ_MASK_EN
  assign w_win_ok = (w_idx <= c_win_dev);
`else
  assign w_win_ok = (w_idx < c_win_dev);
`endif
  assign w_hit = (pr_addr[31:8] == BASE[31:8]) && w_win_ok && (pr_addr[1:0] == 2'b00);

  // Window DEV_CNT (mask register) never matches a device, so it never drives dev_sel.
  always_comb begin
    w_dev_ack = 1'b0;
    w_dev_rd  = '0;
    w_sel     = '0;
    for (int i = 0; i < DEV_CNT; i++) begin
      if (r_idx == PR_WIN_BITS'(i)) begin
        w_dev_ack = dev_ack[i];
        w_dev_rd  = dev_rdata[32*i +: 32];
        w_sel[i]  = (r_state == ST_ACCESS);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_accept     = 1'b0;
    w_resp       = 1'b0;
    w_resp_err   = 1'b0;
    w_resp_rdata = '0;
    w_cnt_inc    = 1'b0;
`ifdef PR_IRQ_MASK_EN
    w_mask_wr    = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (pr_req) begin
          if (w_hit) begin
            w_accept    = 1'b1;
            w_state_nxt = ST_ACCESS;
          end else begin
            w_resp      = 1'b1;
            w_resp_err  = 1'b1;
            w_state_nxt = ST_RESP;
          end
        end
      end
      ST_ACCESS: begin
`ifdef PR_IRQ_MASK_EN
        if (r_idx == c_win_dev) begin
          w_resp       = 1'b1;
          w_mask_wr    = r_we && (r_addr == 2'b00);
          w_resp_rdata = (!r_we && (r_addr == 2'b00)) ? 32'(r_mask) : '0;
        end else
`endif
        if (w_dev_ack) begin
          w_resp       = 1'b1;
          w_resp_rdata = r_we ? '0 : w_dev_rd;
        end else if (r_cnt == c_cnt_last) begin
          w_resp     = 1'b1;
          w_resp_err = 1'b1;
        end else begin
          w_cnt_inc = 1'b1;
        end
        if (w_resp) begin
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idx   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_cnt   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      r_ready <= w_resp;
      if (w_accept) begin
        r_idx   <= w_idx;
        r_we    <= pr_we;
        r_addr  <= pr_addr[3:2];
        r_wdata <= pr_wdata;
        r_cnt   <= '0;
      end else if (w_cnt_inc) begin
        r_cnt <= r_cnt + c_cnt_w'(1);
      end
      if (w_resp) begin
        r_rdata <= w_resp_rdata;
        r_err   <= w_resp_err;
      end
    end
  end

`ifdef PR_IRQ_MASK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mask <= '1;
    end else if (w_mask_wr) begin
      r_mask <= r_wdata[DEV_CNT-1:0];
    end
  end
  assign w_irq_mask = r_mask;
`else
  assign w_irq_mask = '1;
`endif

  pr_irq_sync #(
    .WIDTH (DEV_CNT)
  ) u_irq_sync (
    .clk    (clk),
    .rst    (rst),
    .irq    (dev_irq),
    .mask   (w_irq_mask),
    .hw_int (hw_int)
  );

  assign pr_rdata  = r_rdata;
  assign pr_err    = r_err;
  assign pr_ready  = r_ready;
  assign dev_sel   = w_sel;
  assign dev_we    = (r_state == ST_ACCESS) && r_we;
  assign dev_addr  = r_addr;
  assign dev_wdata = r_wdata;

endmodule

`default_nettype wire

// File: tb/tb_pr_bridge.sv
// ============================================================================
// Module   : tb_pr_bridge
// Brief    : Directed, table-driven bench for pr_bridge (both PR_IRQ_MASK_EN builds).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pr_bridge;

  localparam int N = 6;

  logic            clk = 1'b0;
  logic            rst;
  logic            pr_req;
  logic            pr_we;
  logic [31:0]     pr_addr;
  logic [31:0]     pr_wdata;
  logic [31:0]     pr_rdata;
  logic            pr_ready;
  logic            pr_err;
  logic [N-1:0]    dev_sel;
  logic            dev_we;
  logic [1:0]      dev_addr;
  logic [31:0]     dev_wdata;
  logic [32*N-1:0] dev_rdata;
  logic [N-1:0]    dev_ack;
  logic [N-1:0]    dev_irq;
  logic [N-1:0]    hw_int;

  int n_tests = 0;
  int n_fail  = 0;

  pr_bridge #(
    .DEV_CNT (N),
    .BASE    (32'h0000_7F00),
    .TIMEOUT (15)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pr_req    (pr_req),
    .pr_we     (pr_we),
    .pr_addr   (pr_addr),
    .pr_wdata  (pr_wdata),
    .pr_rdata  (pr_rdata),
    .pr_ready  (pr_ready),
    .pr_err    (pr_err),
    .dev_sel   (dev_sel),
    .dev_we    (dev_we),
    .dev_addr  (dev_addr),
    .dev_wdata (dev_wdata),
    .dev_rdata (dev_rdata),
    .dev_ack   (dev_ack),
    .dev_irq   (dev_irq),
    .hw_int    (hw_int)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    int          ack_dev;
    int          ack_cyc;     // ACCESS cycle in which the device acks; 0 = never
    logic [31:0] ack_data;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;     // cycles from acceptance to pr_ready
    int          exp_selcnt;
    logic [N-1:0] exp_sel;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string name, input logic [31:0] addr, input logic we,
                              input logic [31:0] wdata, input int ack_dev, input int ack_cyc,
                              input logic [31:0] ack_data, input logic [31:0] exp_rdata,
                              input logic exp_err, input int exp_lat, input int exp_selcnt,
                              input logic [N-1:0] exp_sel);
    vec_t v;
    v.name = name; v.addr = addr; v.we = we; v.wdata = wdata;
    v.ack_dev = ack_dev; v.ack_cyc = ack_cyc; v.ack_data = ack_data;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat;
    v.exp_selcnt = exp_selcnt; v.exp_sel = exp_sel;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drives one request; changes pr_addr/pr_we/pr_wdata after acceptance to
  // confirm the bridge works from its latched copies.
  task automatic run_txn(input vec_t t);
    int lat = 0;
    int selcnt = 0;
    bit seen = 1'b0;
    bit stable = 1'b1;
    logic [31:0] rd = '0;
    logic err = 1'b0;
    logic [N-1:0] noise;
    noise = (t.ack_dev == 5) ? N'(6'b010000) : N'(6'b100000);
    dev_rdata[32*t.ack_dev +: 32] = t.ack_data;
    @(negedge clk);
    pr_req = 1'b1; pr_we = t.we; pr_addr = t.addr; pr_wdata = t.wdata;
    for (int c = 1; c <= 40 && !seen; c++) begin
      @(posedge clk);
      @(negedge clk);
      pr_addr = 32'hFFFF_FFFC; pr_wdata = 32'hA5A5_A5A5; pr_we = ~t.we;
      if (dev_sel != '0) begin
        selcnt++;
        if (dev_sel !== t.exp_sel || dev_we !== t.we || dev_addr !== t.addr[3:2] ||
            dev_wdata !== t.wdata)
          stable = 1'b0;
      end
      if (c == t.ack_cyc)     dev_ack = N'(1) << t.ack_dev;
      else if (c < t.ack_cyc) dev_ack = noise;
      else                    dev_ack = '0;
      if (pr_ready === 1'b1) begin
        seen = 1'b1; lat = c; rd = pr_rdata; err = pr_err;
        pr_req = 1'b0; dev_ack = '0;
      end
    end
    pr_req = 1'b0; dev_ack = '0;
    check({t.name, " latency"}, 32'(lat), 32'(t.exp_lat));
    check({t.name, " rdata"}, rd, t.exp_rdata);
    check({t.name, " err"}, 32'(err), 32'(t.exp_err));
    check({t.name, " sel cycles"}, 32'(selcnt), 32'(t.exp_selcnt));
    check({t.name, " dev bus stable"}, 32'(stable), 32'd1);
    @(negedge clk);
    check({t.name, " ready pulse"}, 32'(pr_ready), 32'd0);
    check({t.name, " rdata hold"}, pr_rdata, t.exp_rdata);
  endtask

  initial begin
    bit got_ready;
    vecs.push_back(mk("rd_hit",   32'h7F14, 1'b0, 32'h0,         1, 1,  32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 2,  1,  6'b000010));
    vecs.push_back(mk("wr_wait",  32'h7F08, 1'b1, 32'h12345678,  0, 3,  32'h11111111, 32'h0,        1'b0, 4,  3,  6'b000001));
    vecs.push_back(mk("miss_idx7",32'h7F70, 1'b0, 32'h0,         0, 0,  32'h0,        32'h0,        1'b1, 1,  0,  6'b000000));
    vecs.push_back(mk("misalign", 32'h7F02, 1'b0, 32'h0,         0, 0,  32'h0,        32'h0,        1'b1, 1,  0,  6'b000000));
    vecs.push_back(mk("bad_base", 32'h8F10, 1'b1, 32'h55,        0, 0,  32'h0,        32'h0,        1'b1, 1,  0,  6'b000000));
    vecs.push_back(mk("timeout",  32'h7F28, 1'b0, 32'h0,         2, 99, 32'h22222222, 32'h0,        1'b1, 16, 15, 6'b000100));
    vecs.push_back(mk("ack_last", 32'h7F24, 1'b0, 32'h0,         2, 15, 32'h0BADC0DE, 32'h0BADC0DE, 1'b0, 16, 15, 6'b000100));
    vecs.push_back(mk("rd_dev5",  32'h7F5C, 1'b0, 32'h0,         5, 2,  32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 3,  2,  6'b100000));
`ifdef PR_IRQ_MASK_EN
    vecs.push_back(mk("mask_rd",  32'h7F60, 1'b0, 32'h0,         0, 0,  32'h0,        32'h0000003F, 1'b0, 2,  0,  6'b000000));
    vecs.push_back(mk("mask_off1",32'h7F64, 1'b0, 32'h0,         0, 0,  32'h0,        32'h0,        1'b0, 2,  0,  6'b000000));
`else
    vecs.push_back(mk("win6_miss",32'h7F60, 1'b0, 32'h0,         0, 0,  32'h0,        32'h0,        1'b1, 1,  0,  6'b000000));
`endif

    rst = 1'b0; pr_req = 1'b0; pr_we = 1'b0; pr_addr = '0; pr_wdata = '0;
    dev_rdata = '0; dev_ack = '0; dev_irq = '0;
    for (int i = 0; i < N; i++) dev_rdata[32*i +: 32] = 32'hC0DE_0000 + 32'(i);
    repeat (3) @(negedge clk);
    check("reset pr_ready", 32'(pr_ready), 32'd0);
    check("reset pr_err", 32'(pr_err), 32'd0);
    check("reset pr_rdata", pr_rdata, 32'd0);
    check("reset dev_sel", 32'(dev_sel), 32'd0);
    check("reset dev_we", 32'(dev_we), 32'd0);
    check("reset hw_int", 32'(hw_int), 32'd0);
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) run_txn(vecs[i]);

    // A late ack in IDLE must not produce a response.
    got_ready = 1'b0;
    dev_ack = N'(6'b000100);
    repeat (3) begin @(negedge clk); got_ready |= pr_ready; end
    dev_ack = '0;
    check("late ack ignored", 32'(got_ready), 32'd0);

    // Reset in ACCESS aborts the transaction without a response.
    @(negedge clk);
    pr_req = 1'b1; pr_we = 1'b0; pr_addr = 32'h7F14;
    repeat (3) @(negedge clk);
    check("pre-abort dev_sel", 32'(dev_sel), 32'h2);
    rst = 1'b0;
    #1;
    check("abort dev_sel", 32'(dev_sel), 32'd0);
    pr_req = 1'b0;
    got_ready = 1'b0;
    repeat (2) begin @(negedge clk); got_ready |= pr_ready; end
    check("abort no ready", 32'(got_ready), 32'd0);
    rst = 1'b1;
    run_txn(vecs[0]);

    // Interrupt synchroniser: two edges of latency, level follows.
    @(negedge clk);
    dev_irq = N'(6'b001000);
    @(negedge clk);
    check("irq after 1 edge", 32'(hw_int), 32'd0);
    @(negedge clk);
    check("irq after 2 edges", 32'(hw_int), 32'h8);
    dev_irq = '0;
    repeat (2) @(negedge clk);
    check("irq released", 32'(hw_int), 32'd0);

`ifdef PR_IRQ_MASK_EN
    run_txn(mk("mask_wr0", 32'h7F60, 1'b1, 32'h0, 0, 0, 32'h0, 32'h0, 1'b0, 2, 0, 6'b000000));
    dev_irq = N'(6'b001000);
    repeat (3) @(negedge clk);
    check("masked irq", 32'(hw_int), 32'd0);
    dev_irq = '0;
    run_txn(mk("mask_rdback", 32'h7F60, 1'b0, 32'h0, 0, 0, 32'h0, 32'h0, 1'b0, 2, 0, 6'b000000));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
